// File: rtl/gps_synth_pkg.sv
// gps_synth_pkg: shared widths, LUT/scale constant functions and round/saturate helpers
// for the satellite channel datapath.
package gps_synth_pkg;

    localparam int PHASE_W_D = 32;
    localparam int NCO_W_D   = 9;
    localparam int OUT_W_D   = 16;

    // A registered chip of 1 maps to the -1 symbol on quadrature.
    localparam logic CHIP_NEG = 1'b1;

    // round(2^(nco_w-1)/sqrt(2)) = round(sqrt(2^(2*nco_w-3))), via floor(sqrt(4x)).
    function automatic int p_const(input int nco_w);
        longint v, r, t;
        v = 64'sd1 <<< (2 * nco_w - 1);
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'sd1 <<< b);
            if (t * t <= v) r = t;
        end
        return int'((r + 1) >>> 1);
    endfunction

    // round(amp * sin(pi/2 * k/q)), Taylor series in Q30 fixed point.
    function automatic int sin_entry(input int k, input int q, input int amp);
        longint x, t, s;
        x = longint'(k) * 64'sd1686629713 / longint'(q);
        t = x;
        s = x;
        for (int n = 1; n <= 10; n++) begin
            t = -((((t * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
            s = s + t;
        end
        return int'((longint'(amp) * s + (64'sd1 <<< 29)) >>> 30);
    endfunction

    function automatic longint rnd_shift(input longint v, input int s);
        return (s == 0) ? v : (v + (64'sd1 <<< (s - 1))) >>> s;
    endfunction

    function automatic longint sat_val(input longint v, input int w);
        longint lim;
        lim = (64'sd1 <<< (w - 1)) - 1;
        return (v > lim) ? lim : (v < -lim) ? -lim : v;
    endfunction

    function automatic logic sat_hit(input longint v, input int w);
        longint lim;
        lim = (64'sd1 <<< (w - 1)) - 1;
        return (v > lim) || (v < -lim);
    endfunction

endpackage

// File: rtl/doppler_nco_lut.sv
// doppler_nco_lut: phase accumulator with quadrant-folded quarter-wave cos/sin table,
// output registered on the same enable that advances the phase.
module doppler_nco_lut
    import gps_synth_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_D,
    parameter int LUT_AW  = 8,
    parameter int NCO_W   = NCO_W_D
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [PHASE_W-1:0]      freq,
    output logic signed [NCO_W-1:0] cos_out,
    output logic signed [NCO_W-1:0] sin_out
);
    localparam int Q   = 1 << (LUT_AW - 2);
    localparam int AMP = (1 << (NCO_W - 1)) - 1;

    logic signed [NCO_W-1:0] tab [0:Q];
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [LUT_AW-1:0]       a_s, a_c;
    logic signed [NCO_W-1:0] cos_q, cos_d, sin_q, sin_d;

    for (genvar k = 0; k <= Q; k++) begin : g_tab
        localparam int V = sin_entry(k, Q, AMP);
        assign tab[k] = NCO_W'(V);
    end

    function automatic logic signed [NCO_W-1:0] fold(input logic [LUT_AW-1:0] a);
        logic [LUT_AW-2:0] r;
        r = a[LUT_AW-2] ? (LUT_AW-1)'(Q) - {1'b0, a[LUT_AW-3:0]} : {1'b0, a[LUT_AW-3:0]};
        return a[LUT_AW-1] ? -tab[r] : tab[r];
    endfunction

    always_comb begin
        a_s     = phase_q[PHASE_W-1 -: LUT_AW];
        a_c     = a_s + LUT_AW'(Q);
        phase_d = en ? phase_q + freq : phase_q;
        cos_d   = en ? fold(a_c) : cos_q;
        sin_d   = en ? fold(a_s) : sin_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign cos_out = cos_q;
    assign sin_out = sin_q;

endmodule

// File: rtl/sat_chan_mod.sv
// sat_chan_mod: one satellite's complex baseband contribution; config is staged and
// committed on C/A epochs, gain ramps toward target, output rounded and saturated.
module sat_chan_mod
    import gps_synth_pkg::*;
#(
    parameter int PHASE_W   = PHASE_W_D,
    parameter int LUT_AW    = 8,
    parameter int NCO_W     = NCO_W_D,
    parameter int GAIN_W    = 16,
    parameter int OUT_W     = OUT_W_D,
    parameter int CA_W      = 36,
    parameter int RAMP_STEP = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [CA_W-1:0]         ca_seq,
    input  logic                    ca_epoch,
    input  logic                    nav_bit,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [PHASE_W-1:0]      cfg_freq,
    input  logic [GAIN_W-1:0]       cfg_gain,
    input  logic [$clog2(CA_W)-1:0] cfg_ca_sel,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] real_out,
    output logic signed [OUT_W-1:0] imag_out,
    output logic                    clip,
    output logic                    gain_settled
);
    localparam int SEL_W = $clog2(CA_W);
    localparam int S     = NCO_W + GAIN_W - OUT_W;
    localparam int PW    = NCO_W + GAIN_W + 1;
    localparam longint P = longint'(p_const(NCO_W));
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(RAMP_STEP);

    logic [PHASE_W-1:0]      freq_q, freq_d, stg_freq_q, stg_freq_d;
    logic [GAIN_W-1:0]       cur_gain_q, cur_gain_d, tgt_gain_q, tgt_gain_d;
    logic [GAIN_W-1:0]       stg_gain_q, stg_gain_d, diff, step;
    logic [SEL_W-1:0]        ca_sel_q, ca_sel_d, stg_sel_q, stg_sel_d;
    logic                    pending_q, pending_d, accept, commit;
    logic [3:0]              v_q, v_d;
    logic                    chip_q, chip_d, qen_q, qen_d, clip_q, clip_d;
    logic signed [NCO_W-1:0] cos_w, sin_w, i_q, i_d, qv_q, qv_d;
    logic signed [PW-1:0]    pi_q, pi_d, pq_q, pq_d;
    logic signed [OUT_W-1:0] re_q, re_d, im_q, im_d;
    longint                  ri, rq;

    doppler_nco_lut #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .NCO_W(NCO_W)) u_nco (
        .clk(clk), .rst(rst), .en(enable), .freq(freq_q), .cos_out(cos_w), .sin_out(sin_w)
    );

    always_comb begin
        accept     = cfg_valid && !pending_q;
        commit     = ca_epoch && pending_q;
        pending_d  = accept ? 1'b1 : commit ? 1'b0 : pending_q;
        stg_freq_d = accept ? cfg_freq : stg_freq_q;
        stg_gain_d = accept ? cfg_gain : stg_gain_q;
        stg_sel_d  = accept ? cfg_ca_sel : stg_sel_q;
        freq_d     = commit ? stg_freq_q : freq_q;
        tgt_gain_d = commit ? stg_gain_q : tgt_gain_q;
        ca_sel_d   = commit ? stg_sel_q : ca_sel_q;
        diff       = (tgt_gain_q > cur_gain_q) ? tgt_gain_q - cur_gain_q : cur_gain_q - tgt_gain_q;
        step       = (diff > STEP) ? STEP : diff;
        cur_gain_d = (RAMP_STEP == 0) ? (commit ? stg_gain_q : cur_gain_q) :
                     !enable ? cur_gain_q :
                     (tgt_gain_q > cur_gain_q) ? cur_gain_q + step : cur_gain_q - step;
    end

    // Stage registers hold between valids; only the valid shift register runs every cycle.
    always_comb begin
        v_d    = {v_q[2:0], enable};
        chip_d = enable ? (32'(ca_sel_q) < CA_W) && (ca_seq[ca_sel_q] ^ nav_bit) : chip_q;
        qen_d  = enable ? (32'(ca_sel_q) < CA_W) : qen_q;
        i_d    = v_q[0] ? NCO_W'(rnd_shift(longint'(cos_w) * P, NCO_W - 1)) : i_q;
        qv_d   = v_q[0] ? (!qen_q ? '0 : (chip_q == CHIP_NEG) ? -sin_w : sin_w) : qv_q;
        pi_d   = v_q[1] ? PW'(longint'(i_q) * longint'({1'b0, cur_gain_q})) : pi_q;
        pq_d   = v_q[1] ? PW'(longint'(qv_q) * longint'({1'b0, cur_gain_q})) : pq_q;
        ri     = rnd_shift(longint'(pi_q), S);
        rq     = rnd_shift(longint'(pq_q), S);
        re_d   = v_q[2] ? OUT_W'(sat_val(ri, OUT_W)) : re_q;
        im_d   = v_q[2] ? OUT_W'(sat_val(rq, OUT_W)) : im_q;
        clip_d = v_q[2] && (sat_hit(ri, OUT_W) || sat_hit(rq, OUT_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= 1'b0;
            stg_freq_q <= '0;
            stg_gain_q <= '0;
            stg_sel_q  <= '0;
            freq_q     <= '0;
            tgt_gain_q <= '0;
            cur_gain_q <= '0;
            ca_sel_q   <= '0;
            v_q        <= '0;
            chip_q     <= 1'b0;
            qen_q      <= 1'b0;
            i_q        <= '0;
            qv_q       <= '0;
            pi_q       <= '0;
            pq_q       <= '0;
            re_q       <= '0;
            im_q       <= '0;
            clip_q     <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            stg_freq_q <= stg_freq_d;
            stg_gain_q <= stg_gain_d;
            stg_sel_q  <= stg_sel_d;
            freq_q     <= freq_d;
            tgt_gain_q <= tgt_gain_d;
            cur_gain_q <= cur_gain_d;
            ca_sel_q   <= ca_sel_d;
            v_q        <= v_d;
            chip_q     <= chip_d;
            qen_q      <= qen_d;
            i_q        <= i_d;
            qv_q       <= qv_d;
            pi_q       <= pi_d;
            pq_q       <= pq_d;
            re_q       <= re_d;
            im_q       <= im_d;
            clip_q     <= clip_d;
        end
    end

    assign cfg_ready    = !pending_q;
    assign out_valid    = v_q[3];
    assign real_out     = re_q;
    assign imag_out     = im_q;
    assign clip         = clip_q;
    assign gain_settled = (cur_gain_q == tgt_gain_q);

endmodule

// File: tb/tb_sat_chan_mod.sv
// tb_sat_chan_mod: directed checks of sat_chan_mod with immediate ramp (u0) and
// default ramp (u1) instances sharing one stimulus stream.
module tb_sat_chan_mod;
    logic               clk = 0, rst = 0, enable = 0, ca_epoch = 0, nav_bit = 0, cfg_valid = 0;
    logic [35:0]        ca_seq = 36'h9_3C5A_F0E1;
    logic [31:0]        cfg_freq = '0;
    logic [15:0]        cfg_gain = '0;
    logic [5:0]         cfg_ca_sel = '0;
    logic               rdy0, rdy1, ov0, ov1, clip0, clip1, gs0, gs1;
    logic signed [15:0] re0, re1, im0, im1;
    int                 vectors = 0, miscompares = 0, ph = 0;
    logic               oob = 0;
    logic               dv [4] = '{0, 0, 0, 0};
    int                 dr [4], di [4];
    int                 R [4] = '{23040, 0, -23040, 0};
    int                 QI [4] = '{0, 32640, 0, -32640};
    logic [11:0]        tc = 12'hA20, tn = 12'h280;

    always #5 clk = ~clk;

    sat_chan_mod #(.RAMP_STEP(0)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .ca_seq(ca_seq), .ca_epoch(ca_epoch),
        .nav_bit(nav_bit), .cfg_valid(cfg_valid), .cfg_ready(rdy0), .cfg_freq(cfg_freq),
        .cfg_gain(cfg_gain), .cfg_ca_sel(cfg_ca_sel), .out_valid(ov0), .real_out(re0),
        .imag_out(im0), .clip(clip0), .gain_settled(gs0)
    );

    sat_chan_mod u1 (
        .clk(clk), .rst(rst), .enable(enable), .ca_seq(ca_seq), .ca_epoch(ca_epoch),
        .nav_bit(nav_bit), .cfg_valid(cfg_valid), .cfg_ready(rdy1), .cfg_freq(cfg_freq),
        .cfg_gain(cfg_gain), .cfg_ca_sel(cfg_ca_sel), .out_valid(ov1), .real_out(re1),
        .imag_out(im1), .clip(clip1), .gain_settled(gs1)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [31:0] f, input logic [15:0] g, input logic [5:0] s);
        cfg_valid = 1; cfg_freq = f; cfg_gain = g; cfg_ca_sel = s;
        tick();
        cfg_valid = 0;
        chk("cfg_ready_after_accept", rdy0, 0);
        ca_epoch = 1;
        tick();
        ca_epoch = 0;
        chk("cfg_ready_after_commit", rdy0, 1);
    endtask

    // Expected samples travel a 4-deep delay line matching the stated latency.
    task automatic step(input logic en, input logic c, input logic n);
        enable = en; ca_seq[3] = c; nav_bit = n;
        tick();
        for (int k = 3; k > 0; k--) begin
            dv[k] = dv[k-1]; dr[k] = dr[k-1]; di[k] = di[k-1];
        end
        dv[0] = en;
        dr[0] = R[ph];
        di[0] = oob ? 0 : (c ^ n) ? -QI[ph] : QI[ph];
        if (en) ph = (ph + 1) % 4;
        chk("out_valid", ov0, dv[3]);
        if (dv[3]) begin
            chk("real_out", re0, dr[3]);
            chk("imag_out", im0, di[3]);
            chk("clip", clip0, 0);
        end
    endtask

    initial begin
        #1 rst = 1;
        #1;
        chk("rst_cfg_ready", rdy0, 1);
        chk("rst_out_valid", ov0, 0);
        chk("rst_clip", clip0, 0);
        chk("rst_real", re0, 0);
        chk("rst_imag", im0, 0);
        chk("rst_settled0", gs0, 1);
        chk("rst_settled1", gs1, 1);
        rst = 0;
        enable = 1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("latency_valid", ov0, k == 4);
        end
        chk("idle_real", re0, 0);
        chk("idle_imag", im0, 0);
        chk("idle_ready", rdy0, 1);
        chk("idle_settled", gs1, 1);

        cfg_valid = 1; cfg_freq = 0; cfg_gain = 16'd1000; cfg_ca_sel = 6'd3;
        tick();
        cfg_freq = 32'h4000_0000; cfg_gain = 16'd2000;
        repeat (100) tick();
        chk("hold_ready", rdy0, 0);
        chk("hold_real", re0, 0);
        chk("hold_settled", gs1, 1);
        cfg_valid = 0; enable = 0; ca_epoch = 1;
        tick();
        ca_epoch = 0;
        chk("commit_ready", rdy0, 1);
        chk("commit_target", u1.tgt_gain_q, 1000);
        chk("commit_immediate", u0.cur_gain_q, 1000);
        chk("commit_settled0", gs0, 1);
        chk("commit_settled1", gs1, 0);
        enable = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("ramp_gain", u1.cur_gain_q, (k < 16) ? 64 * k : 1000);
            chk("ramp_settled", gs1, k == 16);
        end

        enable = 0; rst = 1;
        tick();
        rst = 0;
        ph = 0;
        configure(32'h4000_0000, 16'hFFFF, 6'd3);
        for (int j = 0; j < 12; j++) step(1, tc[j], tn[j]);
        repeat (4) step(0, 0, 0);

        configure(32'h4000_0000, 16'hFFFF, 6'd40);
        oob = 1;
        repeat (6) step(1, 1, 0);
        rst = 1;
        #1;
        chk("async_rst_valid", ov0, 0);
        chk("async_rst_real", re0, 0);
        chk("async_rst_imag", im0, 0);
        chk("async_rst_settled", gs1, 1);
        enable = 0;
        tick();
        rst = 0;
        repeat (4) tick();
        chk("flushed_valid", ov0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sat_chan_mod.md
Name: sat_chan_mod

Overview:
- Parametrised, configurable successor to the single-PRN satellite channel in the GPS synthesizer.
- Generates one satellite's complex baseband contribution: Doppler NCO, 1/sqrt(2) in-phase scaling, C/A chip XOR navigation bit on quadrature, linearly ramped gain, round+saturate output.
- Config (freq/gain/PRN tap) is staged via valid/ready and committed only on a C/A epoch strobe, so changes land on code-period boundaries.
- Instantiated N times beside the shared C/A code generator bank; outputs feed the channel summer.

Parameters:
PHASE_W, 32, NCO phase accumulator / freq width
LUT_AW, 8, phase bits addressing the cos/sin LUT
NCO_W, 9, signed NCO sample width
GAIN_W, 16, unsigned gain width
OUT_W, 16, signed output width
CA_W, 36, width of shared chip vector (one bit per PRN)
RAMP_STEP, 64, max gain change per enabled cycle; 0 = immediate

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  sample strobe; advances NCO and enters a sample into the pipe
ca_seq  in  CA_W  current chip of every PRN, from code generator bank
ca_epoch  in  1  single-cycle C/A period boundary strobe
nav_bit  in  1  navigation data bit for this channel
cfg_valid  in  1  staged config offered
cfg_ready  out  1  staging register empty
cfg_freq  in  PHASE_W  Doppler phase increment (two's complement)
cfg_gain  in  GAIN_W  target gain
cfg_ca_sel  in  $clog2(CA_W)  PRN tap index
out_valid  out  1  real_out/imag_out valid
real_out  out  OUT_W  signed in-phase sample
imag_out  out  OUT_W  signed quadrature sample
clip  out  1  pulse: either output saturated this sample
gain_settled  out  1  current gain == target gain

Behaviour:
- Reset: phase, freq, ca_sel, cur_gain, tgt_gain = 0; pending = 0; cfg_ready = 1; out_valid, clip = 0; real_out/imag_out = 0; gain_settled = 1.
- Handshake: accept when cfg_valid && cfg_ready; capture to staging, pending = 1, cfg_ready = 0 next cycle. cfg_valid with cfg_ready low: held, no capture.
- Commit: ca_epoch && pending -> freq, ca_sel, tgt_gain loaded; pending = 0; cfg_ready = 1 next cycle. Epoch without pending: no effect. Accept and epoch in same cycle with pending = 0: capture only; commit waits for next epoch.
- Gain ramp: on each enable, cur_gain moves toward tgt_gain by min(RAMP_STEP, |diff|). RAMP_STEP = 0: cur_gain = tgt_gain at commit. Never overshoots. gain_settled is combinational compare.
- Stage 1 (enable): phase += freq (mod 2^PHASE_W). LUT at phase[PHASE_W-1 -: LUT_AW] (pre-add phase) gives cos and sin, each round((2^(NCO_W-1)-1)*f). Chip = ca_seq[ca_sel] XOR nav_bit, registered alongside. ca_sel >= CA_W: chip forced 0, quadrature forced 0.
- Stage 2: I = round-half-up(cos*P/2^(NCO_W-1)), P = round(2^(NCO_W-1)/sqrt2) = 181 by default. Q = chip ? -sin : sin.
- Stage 3: I*cur_gain and Q*cur_gain, signed x unsigned, full precision; cur_gain sampled this stage.
- Stage 4: shift S = NCO_W+GAIN_W-OUT_W with round half-up (add 2^(S-1)); saturate to +/-(2^(OUT_W-1)-1); clip = 1 when either saturated.
- Latency: out_valid = enable delayed exactly 4 cycles. Pipeline is free-running; outputs hold between valids.
- freq change applies from the first enable after commit; phase is not reset.
- Reset mid-operation: all state cleared asynchronously; in-flight samples discarded.

Decomposition:
- gps_synth_pkg: PHASE_W/NCO_W/OUT_W defaults, P constant function, round-saturate function, chip sign convention (1 = x-1).
- Sub-module doppler_nco_lut: phase accumulator plus quadrant-folded quarter-wave LUT, 1-cycle registered output.

Test Plan:
- Reset then enable every cycle, no config -> out_valid 4 cycles after first enable, outputs 0, cfg_ready = 1, gain_settled = 1.
- RAMP_STEP = 0; cfg freq = 2^30, gain = 65535, ca_sel = 3, ca_seq[3] = 0, nav = 0; epoch -> real 23040, 0, -23040, 0; imag 0, 32640, 0, -32640; clip = 0.
- Same setup, toggle ca_seq[3] or nav_bit -> imag sign flips on the sample entering stage 1 that cycle; both set -> no flip.
- Config accepted with no epoch for 100 cycles -> outputs unchanged, cfg_ready = 0; second cfg_valid not captured; epoch -> commit, cfg_ready = 1 next cycle.
- Default RAMP_STEP = 64, gain 0 -> 1000 -> gain_settled low for exactly 16 enabled cycles; cur_gain 64, 128, ... 960, 1000.
- ca_sel = 40 -> imag 0 while real is nonzero; assert rst mid-stream -> outputs and out_valid go 0 immediately.
